alu_seq_ctrl: RTL

- Upstream operand/command sequencer for the 4-bit combinational ALU and its 7-segment display path.
- Steps the user through loading A, then B, then the opcode, using one "next" key and the data switches.
- Drives the ALU operand and select inputs from registers, then captures the ALU result and flags one cycle later.
- Holds the captured result with a valid/ready handshake toward the display/consumer stage.

---
 rtl/alu_seq_ctrl_pkg.sv | 22 ++
 rtl/alu_seq_ctrl_if.sv | 29 ++
 rtl/alu_seq_ctrl_key_sync_edge.sv | 27 ++
 rtl/alu_seq_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU operand/command sequencer.
package alu_seq_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int SEL_W_DEF = 3;

    // Sequencer state; the encoding is also exposed on the status LEDs.
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Bit positions inside the {OF,ZF,CF,SF} flag vector.
    localparam int FLAG_OF = 3;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_CF = 1;
    localparam int FLAG_SF = 0;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// ALU operand/result bus plus the result valid/ready handshake.
interface alu_seq_ctrl_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH:0]   alu_out;
    logic [3:0]       alu_flags;
    logic [WIDTH:0]   res_q;
    logic [3:0]       flags_q;
    logic             res_valid;
    logic             res_ready;

    // Sequencer side: drives operands and the held result.
    modport master (
        output alu_a, alu_b, alu_sel, res_q, flags_q, res_valid,
        input  alu_out, alu_flags, res_ready
    );

    // ALU / consumer side.
    modport slave (
        input  alu_a, alu_b, alu_sel, res_q, flags_q, res_valid,
        output alu_out, alu_flags, res_ready
    );
endinterface

// File: rtl/alu_seq_ctrl_key_sync_edge.sv
// Synchronises the raw "next" push-button and emits a one-cycle rising-edge pulse.
module key_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_pulse
);
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev_p;

    // Shift the key level through the synchroniser and keep one delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
            prev_p <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], key_in};
            prev_p <= sync_p[SYNC_STAGES-1];
        end
    end

    // High only on the first cycle the synchronised level is seen high.
    assign key_pulse = sync_p[SYNC_STAGES-1] & ~prev_p;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Steps the user through loading A, B and the opcode, then captures and holds the ALU result.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_next,
    input  logic              clr,
    input  logic [WIDTH-1:0]  sw_data,
    input  logic [SEL_W-1:0]  sw_sel,
    output logic [2:0]        stage,
    alu_seq_ctrl_if.master    bus
);
    state_t           state;
    logic             key_pulse;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH:0]   res_r;
    logic [3:0]       flags_r;
    logic             valid_r;

    key_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_next),
        .key_pulse (key_pulse)
    );

    // Sequencer FSM with operand and result registers; clr overrides everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_r   <= '0;
            flags_r <= '0;
            valid_r <= 1'b0;
        end else if (clr) begin
            // The last captured result is deliberately left visible.
            state   <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (key_pulse) begin
                        a_q   <= sw_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (key_pulse) begin
                        b_q   <= sw_data;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (key_pulse) begin
                        sel_q <= sw_sel;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for this whole cycle, so the ALU output is settled.
                    res_r   <= bus.alu_out;
                    flags_r <= bus.alu_flags;
                    valid_r <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    // Key presses here are dropped; only the consumer can release the result.
                    if (bus.res_ready) begin
                        valid_r <= 1'b0;
                        state   <= S_A;
                    end
                end
                default: begin
                    state   <= S_A;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_sel   = sel_q;
    assign bus.res_q     = res_r;
    assign bus.flags_q   = flags_r;
    assign bus.res_valid = valid_r;
    assign stage         = state;

endmodule
